bit_4: RTL and testbench

BIT_4 -- requirements
Module: bit_4

---
 rtl/bit_4.sv | 58 +++++
 tb/tb_bit_4.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bit_4.sv
// bit_4: registered 4-bit carry-lookahead adder with group P/G and overflow flags
module bit_4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin,
    output logic [3:0] S,
    output logic       cout,
    output logic       P,
    output logic       G,
    output logic       ovf
);
    logic [3:0] p, g;
    logic [4:0] c;
    logic [3:0] s_d, s_q;
    logic       cout_d, cout_q, p_d, p_q, g_d, g_q, ovf_d, ovf_q;

    // Lookahead carries are flat sum-of-products so no carry ripples bit to bit
    always_comb begin
        p      = A ^ B;
        g      = A & B;
        c[0]   = cin;
        c[1]   = g[0] | (p[0] & c[0]);
        c[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4]   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s_d    = p ^ c[3:0];
        cout_d = c[4];
        p_d    = &p;
        g_d    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        ovf_d  = c[3] ^ c[4];
    end

    // Every output is a flop; reset clears them at once and drops any pending result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            p_q    <= 1'b0;
            g_q    <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
            p_q    <= p_d;
            g_q    <= g_d;
            ovf_q  <= ovf_d;
        end
    end

    assign S    = s_q;
    assign cout = cout_q;
    assign P    = p_q;
    assign G    = g_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_bit_4.sv
// tb_bit_4: randomized and directed checks of bit_4 against an arithmetic model
module tb_bit_4;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic       ci = 1'b0;
    logic [3:0] s;
    logic       co, pp, gg, ov;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] obs;

    bit_4 dut (.clk(clk), .rst(rst), .A(a), .B(b), .cin(ci), .S(s), .cout(co), .P(pp), .G(gg), .ovf(ov));

    always #5 clk = ~clk;
    assign obs = {co, s, pp, gg, ov};

    // expected {cout,S,P,G,ovf} from plain integer arithmetic
    function automatic logic [7:0] model(input int x, input int y, input int c);
        int sum, sx, sy, ss;
        logic [3:0] lo;
        logic pe, ge, oe, ce;
        sum = x + y + c;
        lo  = sum[3:0];
        ce  = (sum > 15);
        pe  = ((x ^ y) == 15);
        ge  = (x + y > 15);
        sx  = (x > 7) ? x - 16 : x;
        sy  = (y > 7) ? y - 16 : y;
        ss  = sx + sy + c;
        oe  = (ss > 7) || (ss < -8);
        return {ce, lo, pe, ge, oe};
    endfunction

    task automatic step(input int x, input int y, input int c);
        @(negedge clk);
        a  = 4'(x);
        b  = 4'(y);
        ci = 1'(c);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 8'h00) begin failures++; $display("FAIL reset_async obs=%h exp=00", obs); end
        a = 4'd15; b = 4'd15; ci = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 8'h00) begin failures++; $display("FAIL reset_hold obs=%h exp=00", obs); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== model(15, 15, 1)) begin failures++; $display("FAIL reset_first_edge obs=%h exp=%h", obs, model(15, 15, 1)); end
    endtask

    task automatic test_directed();
        step(5, 6, 0);
        checks++;
        if (obs !== {1'b0, 4'd11, 1'b0, 1'b0, 1'b1}) begin failures++; $display("FAIL dir_5_6_0 obs=%h exp=%h", obs, {1'b0, 4'd11, 3'b001}); end
        step(0, 14, 1);
        checks++;
        if (obs !== {1'b0, 4'd15, 3'b000}) begin failures++; $display("FAIL dir_0_14_1 obs=%h exp=%h", obs, {1'b0, 4'd15, 3'b000}); end
        step(1, 15, 0);
        checks++;
        if (obs !== {1'b1, 4'd0, 3'b010}) begin failures++; $display("FAIL dir_1_15_0 obs=%h exp=%h", obs, {1'b1, 4'd0, 3'b010}); end
        step(10, 5, 1);
        checks++;
        if (obs !== {1'b1, 4'd0, 3'b100}) begin failures++; $display("FAIL dir_10_5_1 obs=%h exp=%h", obs, {1'b1, 4'd0, 3'b100}); end
        step(15, 15, 1);
        checks++;
        if (obs !== {1'b1, 4'd15, 3'b010}) begin failures++; $display("FAIL dir_15_15_1 obs=%h exp=%h", obs, {1'b1, 4'd15, 3'b010}); end
    endtask

    task automatic test_back_to_back();
        int x, y, c;
        step(3, 2, 1);
        checks++;
        if ({co, s} !== 5'd6) begin failures++; $display("FAIL b2b_3_2_1 obs=%0d exp=6", {co, s}); end
        step(5, 2, 0);
        checks++;
        if ({co, s} !== 5'd7) begin failures++; $display("FAIL b2b_5_2_0 obs=%0d exp=7", {co, s}); end
        for (int i = 0; i < 200; i++) begin
            x = int'($urandom_range(15));
            y = int'($urandom_range(15));
            c = int'($urandom_range(1));
            step(x, y, c);
            checks++;
            if (obs !== model(x, y, c)) begin failures++; $display("FAIL b2b_rand a=%0d b=%0d cin=%0d obs=%h exp=%h", x, y, c, obs, model(x, y, c)); end
        end
    endtask

    task automatic test_hold();
        step(7, 8, 0);
        #2;
        a = 4'd1; b = 4'd1;
        #1;
        checks++;
        if (obs !== model(7, 8, 0)) begin failures++; $display("FAIL hold_between_edges obs=%h exp=%h", obs, model(7, 8, 0)); end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== model(1, 1, 0)) begin failures++; $display("FAIL hold_next_edge obs=%h exp=%h", obs, model(1, 1, 0)); end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== model(1, 1, 0)) begin failures++; $display("FAIL hold_stable obs=%h exp=%h", obs, model(1, 1, 0)); end
    endtask

    task automatic test_midstream_reset();
        step(15, 15, 1);
        checks++;
        if (obs !== model(15, 15, 1)) begin failures++; $display("FAIL mid_pre obs=%h exp=%h", obs, model(15, 15, 1)); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 8'h00) begin failures++; $display("FAIL mid_async_clear obs=%h exp=00", obs); end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 8'h00) begin failures++; $display("FAIL mid_held obs=%h exp=00", obs); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({co, s} !== 5'd31) begin failures++; $display("FAIL mid_after obs=%0d exp=31", {co, s}); end
    endtask

    task automatic test_exhaustive();
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++) begin
                    step(x, y, c);
                    checks++;
                    if (obs !== model(x, y, c)) begin failures++; $display("FAIL sweep a=%0d b=%0d cin=%0d obs=%h exp=%h", x, y, c, obs, model(x, y, c)); end
                end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_hold();
        test_midstream_reset();
        test_exhaustive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
